axil_gpio_regs: RTL

AXI4-Lite slave register block that drives the board LEDs and samples the board switches. It sits directly downstream of the AXI VIP master / interconnect in `design_1`, at base `0x4000_0000`. It decodes only the low address bits. Beyond plain LED and switch registers, it synchronises the switch inputs, latches per-bit change events, and raises a level interrupt.

---
 rtl/axil_gpio_pkg.sv | 59 +++++
 rtl/axil_gpio_sync.sv | 28 ++
 rtl/axil_gpio_regs.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/axil_gpio_pkg.sv
`default_nettype none
// ============================================================================
// axil_gpio_pkg : register offsets, response codes, FSM states, address decode
// Revision: 1.0
// ============================================================================
package axil_gpio_pkg;

   localparam logic [31:0] LED_OFS   = 32'h00;
   localparam logic [31:0] SW_OFS    = 32'h04;
   localparam logic [31:0] EDGE_OFS  = 32'h08;
   localparam logic [31:0] IRQEN_OFS = 32'h0C;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE    = 2'd0,
      W_HAVE_AW = 2'd1,
      W_HAVE_W  = 2'd2,
      W_RESP    = 2'd3
   } wr_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

   typedef enum logic [2:0] {
      SEL_LED   = 3'd0,
      SEL_SW    = 3'd1,
      SEL_EDGE  = 3'd2,
      SEL_IRQEN = 3'd3,
      SEL_NONE  = 3'd4
   } reg_sel_t;

   // Byte lanes within a word are ignored; only the word offset selects.
   function automatic reg_sel_t decode(input logic [31:0] addr);
      reg_sel_t sel;
      case ({addr[31:2], 2'b00})
         LED_OFS:   sel = SEL_LED;
         SW_OFS:    sel = SEL_SW;
         EDGE_OFS:  sel = SEL_EDGE;
         IRQEN_OFS: sel = SEL_IRQEN;
         default:   sel = SEL_NONE;
      endcase
      return sel;
   endfunction

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = {8{strb[i]}};
      end
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axil_gpio_sync.sv
`default_nettype none
// ============================================================================
// axil_gpio_sync : parameterised-width two-flop synchroniser, async reset
// Revision: 1.0
// ============================================================================
module axil_gpio_sync #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule
`default_nettype wire

// File: rtl/axil_gpio_regs.sv
`default_nettype none
// ============================================================================
// axil_gpio_regs : AXI4-Lite LED/switch registers with edge capture and irq
// Revision: 1.0
// ============================================================================
module axil_gpio_regs
   import axil_gpio_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int LED_WIDTH  = 8,
   parameter int SW_WIDTH   = 8
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [LED_WIDTH-1:0]  led,
   input  logic [SW_WIDTH-1:0]   sw,
   output logic                  irq
);

   wr_state_t             wr_state, wr_state_nxt;
   rd_state_t             rd_state, rd_state_nxt;
   logic                  out_of_reset;
   logic                  aw_hs, w_hs, ar_hs, do_write;
   logic [ADDR_WIDTH-1:0] awaddr_q, wr_addr;
   logic [31:0]           wdata_q, wr_data, wr_mask;
   logic [3:0]            wstrb_q, wr_strb;
   reg_sel_t              wr_sel;
   logic [SW_WIDTH-1:0]   sw_sync, sw_prev, edge_bits, edge_clr, irq_en;
   logic [31:0]           rd_val;
   logic [1:0]            rd_resp;

   axil_gpio_sync #(.WIDTH(SW_WIDTH)) u_sync (
      .clk   (aclk),
      .rst_n (aresetn),
      .d     (sw),
      .q     (sw_sync)
   );

   // Readies stay low in reset and rise on the first edge after release.
   assign s_axi_awready = out_of_reset & (wr_state == W_IDLE || wr_state == W_HAVE_W);
   assign s_axi_wready  = out_of_reset & (wr_state == W_IDLE || wr_state == W_HAVE_AW);
   assign s_axi_bvalid  = (wr_state == W_RESP);
   assign s_axi_arready = out_of_reset & (rd_state == R_IDLE);
   assign s_axi_rvalid  = (rd_state == R_DATA);
   assign aw_hs         = s_axi_awvalid & s_axi_awready;
   assign w_hs          = s_axi_wvalid & s_axi_wready;
   assign ar_hs         = s_axi_arvalid & s_axi_arready;

   // The final handshake commits in its own cycle, so bypass the holding regs.
   assign wr_addr  = aw_hs ? s_axi_awaddr : awaddr_q;
   assign wr_data  = w_hs ? s_axi_wdata : wdata_q;
   assign wr_strb  = w_hs ? s_axi_wstrb : wstrb_q;
   assign wr_mask  = strb_mask(wr_strb);
   assign wr_sel   = decode(32'(wr_addr));
   assign edge_clr = (do_write && wr_sel == SEL_EDGE) ? SW_WIDTH'(wr_data & wr_mask) : '0;

   always_comb begin
      wr_state_nxt = wr_state;
      do_write     = 1'b0;
      case (wr_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               wr_state_nxt = W_RESP;
               do_write     = 1'b1;
            end else if (aw_hs) begin
               wr_state_nxt = W_HAVE_AW;
            end else if (w_hs) begin
               wr_state_nxt = W_HAVE_W;
            end
         end
         W_HAVE_AW: if (w_hs) begin
            wr_state_nxt = W_RESP;
            do_write     = 1'b1;
         end
         W_HAVE_W: if (aw_hs) begin
            wr_state_nxt = W_RESP;
            do_write     = 1'b1;
         end
         W_RESP: if (s_axi_bready) wr_state_nxt = W_IDLE;
         default: wr_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      rd_state_nxt = rd_state;
      case (rd_state)
         R_IDLE:  if (ar_hs) rd_state_nxt = R_DATA;
         R_DATA:  if (s_axi_rready) rd_state_nxt = R_IDLE;
         default: rd_state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      rd_val  = '0;
      rd_resp = RESP_OKAY;
      case (decode(32'(s_axi_araddr)))
         SEL_LED:   rd_val = 32'(led);
         SEL_SW:    rd_val = 32'(sw_sync);
         SEL_EDGE:  rd_val = 32'(edge_bits);
         SEL_IRQEN: rd_val = 32'(irq_en);
         default:   rd_resp = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_of_reset <= 1'b0;
         wr_state     <= W_IDLE;
         rd_state     <= R_IDLE;
         awaddr_q     <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         s_axi_bresp  <= RESP_OKAY;
         s_axi_rdata  <= '0;
         s_axi_rresp  <= RESP_OKAY;
         led          <= '0;
         irq_en       <= '0;
         edge_bits    <= '0;
         sw_prev      <= '0;
         irq          <= 1'b0;
      end else begin
         out_of_reset <= 1'b1;
         wr_state     <= wr_state_nxt;
         rd_state     <= rd_state_nxt;
         if (aw_hs) awaddr_q <= s_axi_awaddr;
         if (w_hs) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
         end
         if (do_write) begin
            s_axi_bresp <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
            if (wr_sel == SEL_LED)
               led <= LED_WIDTH'((32'(led) & ~wr_mask) | (wr_data & wr_mask));
            if (wr_sel == SEL_IRQEN)
               irq_en <= SW_WIDTH'((32'(irq_en) & ~wr_mask) | (wr_data & wr_mask));
         end
         if (ar_hs) begin
            s_axi_rdata <= rd_val;
            s_axi_rresp <= rd_resp;
         end
         // OR-ing the new events after the clear lets a same-cycle set win.
         edge_bits <= (edge_bits & ~edge_clr) | (sw_sync ^ sw_prev);
         sw_prev   <= sw_sync;
         irq       <= |(edge_bits & irq_en);
      end
   end

endmodule
`default_nettype wire
